// File: rtl/intersection_pkg.sv
// Shared phase encoding and counter width for the intersection controller slice.
package intersection_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5
  } state_e;

endpackage

// File: rtl/phase_timer.sv
// Dwell counter for one signal phase: clears on phase change, can hold, and
// flags the last cycle of a supplied dwell.
module phase_timer
  import intersection_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             hold_i,
  input  logic [CNT_W-1:0] dwell_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 1'b1;
    if (clr_i)       count_d = '0;
    else if (hold_i) count_d = count_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
  assign done_o  = (count_q == dwell_i - 1'b1);

endmodule

// File: rtl/intersection_controller.sv
// Two-road intersection sequencer: NS rests on green, EW served on vehicle or
// pedestrian demand, with yellow and all-red clearance between conflicting greens.
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int unsigned NS_MIN = 30,
  parameter int unsigned EW_T   = 20,
  parameter int unsigned Y_T    = 4,
  parameter int unsigned AR_T   = 2,
  parameter int unsigned WALK_T = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic ew_car,
  input  logic ped_req,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic walk,
  output logic ped_wait
);

  localparam logic [CNT_W-1:0] NS_LAST = CNT_W'(NS_MIN - 1);
  localparam logic [CNT_W-1:0] WALK_C  = CNT_W'(WALK_T);

  state_e           state_q, state_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_srv_q, ped_srv_d;
  logic [CNT_W-1:0] count, dwell;
  logic             done, hold, clr, demand, at_min;

  phase_timer u_timer (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (clr),
    .hold_i  (hold),
    .dwell_i (dwell),
    .count_o (count),
    .done_o  (done)
  );

  assign demand = ew_car | ped_pend_q;
  assign at_min = (count >= NS_LAST);
  assign clr    = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    hold    = 1'b0;
    dwell   = CNT_W'(NS_MIN);
    unique case (state_q)
      NS_G: begin
        // Without demand the counter parks at NS_MIN-1 so late demand exits at once.
        if (at_min && demand) state_d = NS_Y;
        else if (at_min)      hold    = 1'b1;
      end
      NS_Y: begin
        dwell = CNT_W'(Y_T);
        if (done) state_d = AR1;
      end
      AR1: begin
        dwell = CNT_W'(AR_T);
        if (done) state_d = EW_G;
      end
      EW_G: begin
        dwell = CNT_W'(EW_T);
        if (done) state_d = EW_Y;
      end
      EW_Y: begin
        dwell = CNT_W'(Y_T);
        if (done) state_d = AR2;
      end
      AR2: begin
        dwell = CNT_W'(AR_T);
        if (done) state_d = NS_G;
      end
      default: state_d = AR2;
    endcase
  end

  always_comb begin
    ped_pend_d = ped_pend_q | ped_req;
    ped_srv_d  = ped_srv_q;
    // A press on the EW entry edge is folded into this service rather than re-latched.
    if (state_q == AR1 && state_d == EW_G) begin
      ped_srv_d  = ped_pend_q | ped_req;
      ped_pend_d = 1'b0;
    end else if (state_q == EW_G && state_d != EW_G) begin
      ped_srv_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= AR2;
      ped_pend_q <= 1'b0;
      ped_srv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
      ped_srv_q  <= ped_srv_d;
    end
  end

  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    unique case (state_q)
      NS_G:    begin ns_red = 1'b0; ns_green  = 1'b1; end
      NS_Y:    begin ns_red = 1'b0; ns_yellow = 1'b1; end
      EW_G:    begin ew_red = 1'b0; ew_green  = 1'b1; end
      EW_Y:    begin ew_red = 1'b0; ew_yellow = 1'b1; end
      default: ;
    endcase
  end

  assign walk     = (state_q == EW_G) && ped_srv_q && (count < WALK_C);
  assign ped_wait = ped_pend_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Scoreboard bench: a phase-table reference model predicts every cycle's lamps,
// a separate monitor compares them against the controller on the falling edge.
module tb_intersection_controller;

  localparam int NS_MIN = 30;
  localparam int EW_T   = 20;
  localparam int Y_T    = 4;
  localparam int AR_T   = 2;
  localparam int WALK_T = 10;

  logic clk = 1'b0;
  logic reset, ew_car, ped_req;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_wait;

  always #5 clk = ~clk;

  intersection_controller #(
    .NS_MIN (NS_MIN),
    .EW_T   (EW_T),
    .Y_T    (Y_T),
    .AR_T   (AR_T),
    .WALK_T (WALK_T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ew_car    (ew_car),
    .ped_req   (ped_req),
    .ns_red    (ns_red),
    .ns_yellow (ns_yellow),
    .ns_green  (ns_green),
    .ew_red    (ew_red),
    .ew_yellow (ew_yellow),
    .ew_green  (ew_green),
    .walk      (walk),
    .ped_wait  (ped_wait)
  );

  // Phase table: index 0 NS green, 1 NS yellow, 2 clearance, 3 EW green,
  // 4 EW yellow, 5 clearance. Lamps are {red, yellow, green}.
  int          dur   [6] = '{NS_MIN, Y_T, AR_T, EW_T, Y_T, AR_T};
  logic [2:0]  ns_lmp[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0]  ew_lmp[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  int   ph, el;
  bit   pend, srv, started, m_flag;
  logic [7:0] expq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic model_step(input bit r, input bit e, input bit p);
    bit go;
    if (r) begin
      ph = 5; el = 0; pend = 0; srv = 0;
      return;
    end
    go = (el + 1 >= dur[ph]) && (ph != 0 || e || pend);
    if (ph == 2 && go) begin
      srv  = pend | p;
      pend = 0;
    end else if (p) begin
      pend = 1;
    end
    if (ph == 3 && go) srv = 0;
    if (go) begin
      ph = (ph + 1) % 6;
      el = 0;
    end else begin
      el++;
    end
  endtask

  function automatic logic [7:0] model_out();
    logic w;
    w = (ph == 3) && srv && (el < WALK_T);
    return {ns_lmp[ph], ew_lmp[ph], w, pend};
  endfunction

  // Modes: 0 idle, 1 EW car held, 2 ped pulse at NS green cycle 5, 3 EW car from
  // NS green cycle 100, 4 ped on the EW entry edge, 5 reset in EW green cycle 7,
  // 6 random, 7 reset held.
  task automatic cycles(input int n, input int mode);
    m_flag = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step(reset, ew_car, ped_req);
      started = 1;
      expq.push_back(model_out());
      #1;
      reset = 0; ew_car = 0; ped_req = 0;
      case (mode)
        1: ew_car = 1;
        2: if (ph == 0 && el == 5 && !m_flag) begin ped_req = 1; m_flag = 1; end
        3: ew_car = (ph == 0 && el >= 100);
        4: begin
          ew_car = (ph == 0 && !m_flag);
          if (ph == 2 && el == AR_T - 1 && !m_flag) begin ped_req = 1; m_flag = 1; end
        end
        5: begin
          ew_car = 1;
          if (ph == 3 && el == 7 && !m_flag) begin reset = 1; m_flag = 1; end
        end
        6: begin
          ew_car  = ($urandom_range(0, 3) == 0);
          ped_req = ($urandom_range(0, 15) == 0);
          reset   = ($urandom_range(0, 299) == 0);
        end
        7: reset = 1;
        default: ;
      endcase
    end
  endtask

  initial begin : monitor
    logic [7:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (expq.size() == 0) begin
        if (started) begin
          errors++;
          $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
        end
      end else begin
        exp_v = expq.pop_front();
        act_v = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_wait};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL lamps t=%0t got nsRYG/ewRYG/walk/wait=%b required %b", $time, act_v, exp_v);
        end
        checks++;
        if (((ns_green | ns_yellow) & (ew_green | ew_yellow)) !== 1'b0) begin
          errors++;
          $display("FAIL safety t=%0t got conflict=1 required 0", $time);
        end
      end
    end
  end

  initial begin
    reset = 1; ew_car = 0; ped_req = 0;
    cycles(2, 7);
    cycles(500, 0);
    cycles(1, 7);
    cycles(300, 1);
    cycles(1, 7);
    cycles(200, 2);
    cycles(1, 7);
    cycles(250, 3);
    cycles(1, 7);
    cycles(200, 4);
    cycles(1, 7);
    cycles(150, 5);
    cycles(4000, 6);
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries required 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intersection_controller.md
Name: intersection_controller

Overview:
- Sequences a two-way intersection with signal heads for the north-south (NS, main) and east-west (EW, side) roads, plus one pedestrian WALK lamp that crosses NS.
- NS rests on green. EW is served only on demand: the EW vehicle sensor or a latched pedestrian request.
- Yellow and all-red clearance intervals guarantee the two roads are never green or yellow at the same time.
- Sits above the per-head lamp drivers and owns all phase timing.

Parameters:
- NS_MIN, 30, minimum NS green dwell in clk cycles (1..255)
- EW_T, 20, fixed EW green dwell in cycles (1..255)
- Y_T, 4, yellow dwell for either road (1..255)
- AR_T, 2, all-red clearance dwell (1..255)
- WALK_T, 10, WALK lamp duration at the start of a ped-served EW green (1..EW_T)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- ew_car  in  1  EW vehicle detector, level, synchronous to clk
- ped_req  in  1  pedestrian button, single-cycle or level, synchronous
- ns_red  out  1  NS red lamp
- ns_yellow  out  1  NS yellow lamp
- ns_green  out  1  NS green lamp
- ew_red  out  1  EW red lamp
- ew_yellow  out  1  EW yellow lamp
- ew_green  out  1  EW green lamp
- walk  out  1  pedestrian WALK lamp
- ped_wait  out  1  pedestrian request latched and not yet served

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset (sampled high at an edge):
  - state becomes AR2; count=0; ped_pend=0; ped_srv=0.
  - Outputs: ns_red=1, ew_red=1, all other lamps 0, walk=0, ped_wait=0.
  - A reset asserted mid-phase aborts the phase at that edge. Lamps go all-red in the next cycle.
- States and output decode:
  - NS_G: ns_green, ew_red.
  - NS_Y: ns_yellow, ew_red.
  - AR1: ns_red, ew_red.
  - EW_G: ns_red, ew_green.
  - EW_Y: ns_red, ew_yellow.
  - AR2: ns_red, ew_red.
- Output rules:
  - All lamp outputs are a Moore decode of the state register.
  - Each head shows exactly one lamp at all times.
- Dwell counter:
  - 8-bit count, cleared on every state transition, otherwise incremented.
  - "Dwell D" means the state is held exactly D cycles; the exit fires at the edge where count==D-1.
- Transitions:
  - AR2 -> NS_G after AR_T cycles.
  - NS_G -> NS_Y at an edge where count>=NS_MIN-1 and demand=1, with demand = ew_car | ped_pend.
  - In NS_G with no demand: hold NS_G, and count saturates at NS_MIN-1. Demand arriving later exits at the first edge it is seen.
  - NS_Y -> AR1 after Y_T.
  - AR1 -> EW_G after AR_T.
  - EW_G -> EW_Y after EW_T. The EW green is fixed length and is not extended by ew_car.
  - EW_Y -> AR2 after Y_T.
- Pedestrian latch:
  - ped_pend is set at any edge where ped_req=1.
  - On the AR1->EW_G edge: ped_srv <= ped_pend, and ped_pend is cleared.
  - A ped_req high on that same edge is counted as served, so the clear wins.
  - ped_req arriving during EW_G, EW_Y or AR2 sets ped_pend for the next cycle.
  - ped_wait = ped_pend.
- WALK lamp:
  - walk=1 while state==EW_G && ped_srv && count<WALK_T.
  - ped_srv clears on leaving EW_G.
- Safety invariant: (ns_green|ns_yellow) & (ew_green|ew_yellow) is never 1.

Decomposition:
- Shared package intersection_pkg holds:
  - the 3-bit state encoding constants: NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5;
  - the counter width constant CNT_W=8.
- Sub-module phase_timer:
  - 8-bit counter with synchronous reset, clear and saturate-hold inputs;
  - outputs count and a done compare against a supplied dwell.
- intersection_controller instantiates one phase_timer and contains the state register, the ped latch and the output decode.

Test Plan (defaults unless stated):
- Reset then idle (ew_car=0, ped_req=0) -> all-red for 2 cycles after reset release, then ns_green stays 1 indefinitely (run 500 cycles); walk=0 and ped_wait=0 throughout.
- ew_car held 1 from reset -> periodic cycle of ns_green 30, ns_yellow 4, all-red 2, ew_green 20, ew_yellow 4, all-red 2, then ns_green again; the safety invariant is checked every cycle.
- ped_req one-cycle pulse at NS green cycle 5, ew_car=0:
  - ped_wait=1 from the next cycle;
  - NS green ends after 30 cycles;
  - walk=1 for EW green cycles 0-9 and 0 for cycles 10-19;
  - ped_wait drops on entry to EW green.
- ew_car first raised at NS green cycle 100 -> ns_yellow at the very next cycle, not after a further 30.
- ped_req asserted exactly on the AR1->EW_G edge -> walk asserted in this EW green; ped_wait stays 0 afterwards and no second EW phase is requested.
- reset pulsed during EW green cycle 7 -> next cycle shows ns_red=ew_red=1, walk=0, ped_wait=0; the normal sequence restarts with NS green 2 cycles after release.
